// File: rtl/sfp_div_pkg.sv
// Shared types and defaults for the radix-4 restoring divider.
package sfp_div_pkg;

    localparam int unsigned DIV_WIDTH_DEF = 20;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

endpackage

// File: rtl/sfp_div_r4_step.sv
// One radix-4 restoring iteration: pick the largest multiple of b that fits, retire two quotient bits.
module sfp_div_r4_step
    import sfp_div_pkg::*;
#(
    parameter int unsigned WIDTH = DIV_WIDTH_DEF
) (
    input  logic [WIDTH+1:0] pr,
    input  logic [WIDTH-1:0] dq,
    input  logic [WIDTH+1:0] b1,
    input  logic [WIDTH+1:0] b2,
    input  logic [WIDTH+1:0] b3,
    output logic [WIDTH+1:0] pr_next,
    output logic [WIDTH-1:0] dq_next
);

    localparam int unsigned PW = WIDTH + 2;

    logic [PW-1:0] sh;
    logic [1:0]    digit;

    always_comb begin
        // pr < b always, so shifting in two dividend bits never overflows PW bits
        sh      = PW'({pr, dq[WIDTH-1:WIDTH-2]});
        digit   = 2'd0;
        pr_next = sh;
        if (sh >= b3) begin
            digit   = 2'd3;
            pr_next = sh - b3;
        end else if (sh >= b2) begin
            digit   = 2'd2;
            pr_next = sh - b2;
        end else if (sh >= b1) begin
            digit   = 2'd1;
            pr_next = sh - b1;
        end
        dq_next = {dq[WIDTH-3:0], digit};
    end

endmodule

// File: rtl/sfp_div_r4_pipe.sv
// Iterative radix-4 divider with valid/ready handshake; two quotient bits per cycle, signed or unsigned.
module sfp_div_r4_pipe
    import sfp_div_pkg::*;
#(
    parameter int unsigned WIDTH     = DIV_WIDTH_DEF,
    parameter bit          SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             signed_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quo,
    output logic [WIDTH-1:0] rem,
    output logic             dz
);

    localparam int unsigned PW    = WIDTH + 2;
    localparam int unsigned ITERS = WIDTH / 2;
    localparam int unsigned CNT_W = $clog2(ITERS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);

    div_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]    pr;
    logic [WIDTH-1:0] dq;
    logic [PW-1:0]    b1;
    logic [PW-1:0]    b2;
    logic [PW-1:0]    b3;
    logic             a_msb;
    logic             b_msb;
    logic             smode;
    logic             b_zero;

    logic             s_in;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;
    logic             q_neg;
    logic             r_neg;
    logic [PW-1:0]    pr_nx;
    logic [WIDTH-1:0] dq_nx;

    assign in_ready = rst && (state == IDLE);

    // Operand magnitudes at capture; the most-negative value maps onto its unsigned magnitude.
    always_comb begin
        s_in  = SIGNED_EN && signed_mode;
        a_abs = (s_in && a[WIDTH-1]) ? -a : a;
        b_abs = (s_in && b[WIDTH-1]) ? -b : b;
        q_neg = smode && (a_msb ^ b_msb);
        r_neg = smode && a_msb;
    end

    sfp_div_r4_step #(.WIDTH(WIDTH)) u_step (
        .pr      (pr),
        .dq      (dq),
        .b1      (b1),
        .b2      (b2),
        .b3      (b3),
        .pr_next (pr_nx),
        .dq_next (dq_nx)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            quo       <= '0;
            rem       <= '0;
            dz        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        pr     <= '0;
                        dq     <= a_abs;
                        b1     <= PW'(b_abs);
                        b2     <= PW'({b_abs, 1'b0});
                        b3     <= PW'({b_abs, 1'b0}) + PW'(b_abs);
                        a_msb  <= a[WIDTH-1];
                        b_msb  <= b[WIDTH-1];
                        smode  <= s_in;
                        b_zero <= (b == '0);
                        cnt    <= '0;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    if (b_zero) begin
                        // dq still holds |a|; restoring its sign gives back the raw dividend
                        quo       <= '1;
                        rem       <= r_neg ? -dq : dq;
                        dz        <= 1'b1;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        pr  <= pr_nx;
                        dq  <= dq_nx;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            quo       <= q_neg ? -dq_nx : dq_nx;
                            rem       <= r_neg ? -pr_nx[WIDTH-1:0] : pr_nx[WIDTH-1:0];
                            dz        <= 1'b0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sfp_div_r4_pipe.sv
// Bench for sfp_div_r4_pipe: signed-capable and unsigned-only builds side by side against an arithmetic model.
module tb_sfp_div_r4_pipe;

    localparam int unsigned W = 20;

    typedef struct packed {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
    } res_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         in_valid = 1'b0;
    logic         signed_mode = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [1:0]   in_ready;
    logic [1:0]   out_valid;
    logic [1:0]   dz;
    logic [W-1:0] quo [2];
    logic [W-1:0] rem [2];

    int n_tests = 0;
    int n_fail  = 0;

    // index 0: SIGNED_EN=1, index 1: SIGNED_EN=0
    bit   m_busy [2];
    bit   m_done [2];
    int   m_cnt  [2];
    res_t m_exp  [2];

    sfp_div_r4_pipe #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid[0]),
        .out_ready(out_ready), .quo(quo[0]), .rem(rem[0]), .dz(dz[0])
    );

    sfp_div_r4_pipe #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .a(a), .b(b), .signed_mode(signed_mode), .out_valid(out_valid[1]),
        .out_ready(out_ready), .quo(quo[1]), .rem(rem[1]), .dz(dz[1])
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] t=%0t: got 0x%0h expected 0x%0h", nm, idx, $time, act, exp);
        end
    endtask

    function automatic res_t ref_div(input logic [W-1:0] x, input logic [W-1:0] y, input bit s);
        longint sx, sy, q, r;
        res_t   res;
        if (y == '0) begin
            res.q  = '1;
            res.r  = x;
            res.dz = 1'b1;
            return res;
        end
        sx = s ? longint'($signed(x)) : longint'(x);
        sy = s ? longint'($signed(y)) : longint'(y);
        q  = sx / sy;
        r  = sx % sy;
        res.q  = W'(q);
        res.r  = W'(r);
        res.dz = 1'b0;
        return res;
    endfunction

    // Transaction-level model: accept in idle, result after W/2 cycles (1 for b==0), hold until consumed.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
                m_cnt[i]  = 0;
            end else if (m_done[i]) begin
                if (out_ready) m_done[i] = 1'b0;
            end else if (m_busy[i]) begin
                m_cnt[i]--;
                if (m_cnt[i] == 0) begin
                    m_busy[i] = 1'b0;
                    m_done[i] = 1'b1;
                end
            end else if (in_valid) begin
                m_busy[i] = 1'b1;
                m_cnt[i]  = (b == '0) ? 1 : int'(W / 2);
                m_exp[i]  = ref_div(a, b, signed_mode && (i == 0));
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk("in_ready", i, 32'(in_ready[i]), 32'(rst && !m_busy[i] && !m_done[i]));
            chk("out_valid", i, 32'(out_valid[i]), 32'(m_done[i]));
            if (m_done[i] && out_valid[i]) begin
                chk("model_quo", i, 32'(quo[i]), 32'(m_exp[i].q));
                chk("model_rem", i, 32'(rem[i]), 32'(m_exp[i].r));
                chk("model_dz",  i, 32'(dz[i]),  32'(m_exp[i].dz));
            end
        end
    end

    task automatic txn(input logic [W-1:0] ta, input logic [W-1:0] tb_, input bit ts,
                       input logic [W-1:0] eq, input logic [W-1:0] er, input bit edz, input int elat,
                       input logic [W-1:0] equ, input logic [W-1:0] eru);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; a = ta; b = tb_; signed_mode = ts;
        @(negedge clk);
        // operands wander while busy; the divider must not notice
        in_valid = 1'b0; a = ~ta; b = tb_ + 20'd1; signed_mode = ~ts;
        lat = 0;
        while (!out_valid[0] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("latency", 0, 32'(lat), 32'(elat));
        chk("quo", 0, 32'(quo[0]), 32'(eq));
        chk("rem", 0, 32'(rem[0]), 32'(er));
        chk("dz",  0, 32'(dz[0]),  32'(edz));
        chk("quo", 1, 32'(quo[1]), 32'(equ));
        chk("rem", 1, 32'(rem[1]), 32'(eru));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        res_t r;
        int   lat;

        r = ref_div(20'd1000, 20'd7, 1'b0);
        chk("pin_model_q", 0, 32'(r.q), 32'd142);
        chk("pin_model_r", 0, 32'(r.r), 32'd6);
        r = ref_div(20'hFFC18, 20'd7, 1'b1);
        chk("pin_model_sq", 0, 32'(r.q), 32'hFFF72);
        chk("pin_model_sr", 0, 32'(r.r), 32'hFFFFA);
        r = ref_div(20'h80000, 20'hFFFFF, 1'b1);
        chk("pin_model_wrap", 0, 32'(r.q), 32'h80000);

        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_quo", i, 32'(quo[i]), 32'd0);
            chk("rst_rem", i, 32'(rem[i]), 32'd0);
            chk("rst_dz",  i, 32'(dz[i]),  32'd0);
            chk("rst_in_ready", i, 32'(in_ready[i]), 32'd0);
        end
        rst = 1'b1;

        txn(20'd1000,  20'd7,      1'b0, 20'd142,   20'd6,     1'b0, 10, 20'd142,   20'd6);
        txn(20'hFFC18, 20'd7,      1'b1, 20'hFFF72, 20'hFFFFA, 1'b0, 10, 20'h24895, 20'd5);
        txn(20'd5,     20'd0,      1'b0, 20'hFFFFF, 20'd5,     1'b1, 1,  20'hFFFFF, 20'd5);
        txn(20'h80000, 20'hFFFFF, 1'b1, 20'h80000, 20'd0,     1'b0, 10, 20'd0,     20'h80000);
        txn(20'hFFFFF, 20'd1,      1'b0, 20'hFFFFF, 20'd0,     1'b0, 10, 20'hFFFFF, 20'd0);
        txn(20'd3,     20'd5,      1'b0, 20'd0,     20'd3,     1'b0, 10, 20'd0,     20'd3);
        txn(20'd7,     20'hFFFFE, 1'b1, 20'hFFFFD, 20'd1,     1'b0, 10, 20'd0,     20'd7);
        txn(20'hFFFF9, 20'hFFFFE, 1'b1, 20'd3,     20'hFFFFF, 1'b0, 10, 20'd0,     20'hFFFF9);
        txn(20'hFFFFB, 20'd0,      1'b1, 20'hFFFFF, 20'hFFFFB, 1'b1, 1,  20'hFFFFF, 20'hFFFFB);
        txn(20'hFFFFF, 20'hFFFFF, 1'b0, 20'd1,     20'd0,     1'b0, 10, 20'd1,     20'd0);

        // Backpressure: result must hold while the consumer stalls; new requests are ignored.
        @(negedge clk);
        in_valid = 1'b1; a = 20'd1000; b = 20'd7; signed_mode = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid[0] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                in_valid = 1'b1; a = 20'd9; b = 20'd2;
            end
            chk("hold_valid", 0, 32'(out_valid[0]), 32'd1);
            chk("hold_quo",   0, 32'(quo[0]), 32'd142);
            chk("hold_rem",   0, 32'(rem[0]), 32'd6);
            chk("hold_ready", 0, 32'(in_ready[0]), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("post_hs_ready", 0, 32'(in_ready[0]), 32'd1);

        // Reset mid-computation: the transaction vanishes, then the divider works again.
        @(negedge clk);
        in_valid = 1'b1; a = 20'd1000; b = 20'd7; signed_mode = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_valid", 0, 32'(out_valid[0]), 32'd0);
        chk("abort_ready", 0, 32'(in_ready[0]), 32'd0);
        chk("abort_quo",   0, 32'(quo[0]), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_idle", 0, 32'(in_ready[0]), 32'd1);
        repeat (12) @(negedge clk);
        txn(20'd1000, 20'd7, 1'b0, 20'd142, 20'd6, 1'b0, 10, 20'd142, 20'd6);

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sfp_div_r4_pipe.md
SFP_DIV_R4_PIPE -- requirements
Module: sfp_div_r4_pipe

Interface
REQ-001 SHALL have parameter: WIDTH, 20, operand/result width in bits; even, >= 4.
REQ-002 SHALL have parameter: SIGNED_EN, 1, 1 = signed mode supported, 0 = signed_mode input ignored (unsigned only).
REQ-003 SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-low reset (0 = reset).
REQ-005 SHALL have port: in_valid  input  1  operand request.
REQ-006 SHALL have port: in_ready  output  1  block can accept an operand pair.
REQ-007 SHALL have port: a  input  WIDTH  dividend.
REQ-008 SHALL have port: b  input  WIDTH  divisor.
REQ-009 SHALL have port: signed_mode  input  1  two's-complement operation when 1 and SIGNED_EN=1.
REQ-010 SHALL have port: out_valid  output  1  result registers hold a result.
REQ-011 SHALL have port: out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port: quo  output  WIDTH  quotient.
REQ-013 SHALL have port: rem  output  WIDTH  remainder.
REQ-014 SHALL have port: dz  output  1  divide-by-zero flag, qualified by out_valid.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE with rst high.
REQ-016 SHALL accept on in_valid && in_ready edge: latch |a|, |b| (magnitudes if signed), sign of quotient (a_msb XOR b_msb), sign of remainder (a_msb), signed_mode; clear iteration counter; IDLE->CALC.
REQ-017 SHALL in CALC retire 2 quotient bits per cycle (radix-4 restoring: compare partial remainder against 3b, 2b, b, select digit 3/2/1/0), WIDTH/2 iterations.
REQ-018 SHALL hold partial remainder and 3b/2b multiples at WIDTH+2 bits so no compare truncates.
REQ-019 SHALL on the final iteration edge apply sign correction and register quo/rem/dz, CALC->DONE; out_valid rises exactly WIDTH/2 cycles after acceptance edge (10 cycles for WIDTH=20).
REQ-020 SHALL produce truncation toward zero; rem sign equals dividend sign; a = quo*b + rem holds for all b != 0.
REQ-021 SHALL for b == 0 go IDLE->DONE after acceptance in one cycle: quo = all ones, rem = a, dz = 1.
REQ-022 SHALL for signed a = most-negative, b = -1 return quo = most-negative (wrap), rem = 0, dz = 0.
REQ-023 SHALL hold out_valid, quo, rem, dz stable in DONE until out_ready high; DONE->IDLE on out_valid && out_ready edge.
REQ-024 SHALL ignore in_valid, a, b, signed_mode changes while not in IDLE.
REQ-025 SHALL treat signed_mode as 0 when SIGNED_EN = 0.

Reset
REQ-026 SHALL while rst low at an edge: state IDLE, out_valid 0, quo 0, rem 0, dz 0, counter 0; in_ready 0 while rst low.
REQ-027 SHALL abort any CALC/DONE transaction on reset with no result produced; first acceptance possible the first edge with rst high.

Structure
REQ-028 SHALL place FSM state enum and default WIDTH constant in shared package sfp_div_pkg.
REQ-029 SHALL factor one radix-4 iteration (digit select + shift) into combinational sub-module sfp_div_r4_step, parametrised by WIDTH.

Verification (WIDTH=20)
REQ-030 SHALL check unsigned a=1000, b=7 -> quo=142, rem=6, dz=0, out_valid exactly 10 cycles after accept.
REQ-031 SHALL check signed a=-1000 (0xFFC18), b=7 -> quo=0xFFF72, rem=0xFFFFA; and SIGNED_EN=0 build treats same inputs as unsigned.
REQ-032 SHALL check a=5, b=0 -> quo=0xFFFFF, rem=5, dz=1, out_valid one cycle after accept.
REQ-033 SHALL check signed a=0x80000, b=0xFFFFF -> quo=0x80000, rem=0, dz=0.
REQ-034 SHALL check out_ready held low 5 cycles in DONE -> outputs stable, in_ready 0; new in_valid ignored until handshake.
REQ-035 SHALL check rst low during CALC iteration 4 -> next edge out_valid 0, state IDLE; after release, 1000/7 completes correctly.
